// File: rtl/rv32e_data_mem.sv
// rv32e_data_mem: data-side responder for the rv32e_cpu memory bus.
// Serves whole-word loads/stores from a word RAM and a four-register MMIO page
// (GPIO, free-running cycle counter, console byte FIFO with valid/ready drain).
module rv32e_data_mem #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr_bus,
  input  logic [31:0] mem_write_data_bus,
  input  logic        mem_write_signal,
  output logic [31:0] mem_read_data_bus,
  output logic [31:0] gpio_out,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH);

  localparam logic [CW:0] FifoFull = (CW + 1)'(FIFO_DEPTH);

  // MMIO register select, addr[3:2]
  localparam logic [1:0] RegGpio      = 2'd0;
  localparam logic [1:0] RegCycle     = 2'd1;
  localparam logic [1:0] RegConData   = 2'd2;
  localparam logic [1:0] RegConStatus = 2'd3;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          ram_hit;
  logic          mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [1:0]    reg_sel;
  logic          unused_byte_addr;

  assign ram_hit          = (mem_addr_bus >> (AW + 2)) == 32'd0;
  assign mmio_hit         = mem_addr_bus[31:4] == 28'h1000000;
  assign ram_idx          = mem_addr_bus[AW+1:2];
  assign reg_sel          = mem_addr_bus[3:2];
  // Word-only accesses: byte offset is deliberately ignored.
  assign unused_byte_addr = ^mem_addr_bus[1:0];

  logic wr_ram;
  logic wr_gpio;
  logic wr_cycle;
  logic wr_con_data;
  logic wr_con_status;

  assign wr_ram        = mem_write_signal && ram_hit;
  assign wr_gpio       = mem_write_signal && mmio_hit && (reg_sel == RegGpio);
  assign wr_cycle      = mem_write_signal && mmio_hit && (reg_sel == RegCycle);
  assign wr_con_data   = mem_write_signal && mmio_hit && (reg_sel == RegConData);
  assign wr_con_status = mem_write_signal && mmio_hit && (reg_sel == RegConStatus);

  // ---------------------------------------------------------------------------
  // Word RAM (contents survive reset; reset only blocks the write at its edge)
  // ---------------------------------------------------------------------------
  logic [31:0] ram_q [DEPTH];

  // Commit a store to RAM at the edge the strobe is high.
  always_ff @(posedge clk) begin
    if (reset && wr_ram) begin
      ram_q[ram_idx] <= mem_write_data_bus;
    end
  end

  // ---------------------------------------------------------------------------
  // GPIO and cycle counter
  // ---------------------------------------------------------------------------
  logic [31:0] gpio_q, gpio_d;
  logic [31:0] cycle_q, cycle_d;

  // Next-state for GPIO and CYCLE; a CYCLE write beats that edge's increment.
  always_comb begin
    gpio_d  = wr_gpio ? mem_write_data_bus : gpio_q;
    cycle_d = wr_cycle ? mem_write_data_bus : cycle_q + 32'd1;
  end

  // ---------------------------------------------------------------------------
  // Console FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push_ok;

  assign fifo_full  = count_q == FifoFull;
  assign fifo_empty = count_q == '0;
  assign pop        = !fifo_empty && con_ready;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok    = wr_con_data && (!fifo_full || pop);

  // FIFO pointer, occupancy and sticky-overflow next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + (CW + 1)'(1);
      2'b01:   count_d = count_q - (CW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (wr_con_status) begin
      ovf_d = 1'b0;
    end
    if (wr_con_data && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  // Store an accepted console byte at the write pointer.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      fifo_q[wr_ptr_q] <= mem_write_data_bus[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control state with synchronous active-low reset
  // ---------------------------------------------------------------------------

  // Register MMIO and FIFO control state; reset overrides every write and pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gpio_q   <= 32'd0;
      cycle_q  <= 32'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      gpio_q   <= gpio_d;
      cycle_q  <= cycle_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path (combinational from address and current state)
  // ---------------------------------------------------------------------------
  logic [31:0] con_status;

  // Assemble CON_STATUS: full, empty, occupancy and sticky overflow.
  always_comb begin
    con_status          = 32'd0;
    con_status[0]       = fifo_full;
    con_status[1]       = fifo_empty;
    con_status[CW+2:2]  = count_q;
    con_status[31]      = ovf_q;
  end

  // Read mux; unmapped addresses and CON_DATA read as zero.
  always_comb begin
    mem_read_data_bus = 32'd0;
    if (ram_hit) begin
      mem_read_data_bus = ram_q[ram_idx];
    end else if (mmio_hit) begin
      unique case (reg_sel)
        RegGpio:      mem_read_data_bus = gpio_q;
        RegCycle:     mem_read_data_bus = cycle_q;
        RegConData:   mem_read_data_bus = 32'd0;
        RegConStatus: mem_read_data_bus = con_status;
        default:      mem_read_data_bus = 32'd0;
      endcase
    end
  end

  assign gpio_out  = gpio_q;
  assign con_data  = fifo_q[rd_ptr_q];
  assign con_valid = !fifo_empty;

endmodule

// File: tb/tb_rv32e_data_mem.sv
// Testbench for rv32e_data_mem: directed table of vectors with hand-computed
// expectations, followed by random traffic checked against a behavioural model.
module tb_rv32e_data_mem;

  localparam int unsigned DEPTH      = 256;
  localparam int unsigned FIFO_DEPTH = 4;

  localparam logic [31:0] AGpio = 32'h1000_0000;
  localparam logic [31:0] ACyc  = 32'h1000_0004;
  localparam logic [31:0] ACon  = 32'h1000_0008;
  localparam logic [31:0] AStat = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr_bus;
  logic [31:0] mem_write_data_bus;
  logic        mem_write_signal;
  logic [31:0] mem_read_data_bus;
  logic [31:0] gpio_out;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;

  rv32e_data_mem #(
    .DEPTH      (DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .mem_addr_bus       (mem_addr_bus),
    .mem_write_data_bus (mem_write_data_bus),
    .mem_write_signal   (mem_write_signal),
    .mem_read_data_bus  (mem_read_data_bus),
    .gpio_out           (gpio_out),
    .con_data           (con_data),
    .con_valid          (con_valid),
    .con_ready          (con_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_con;
    logic [7:0]  exp_con;
  } vec_t;

  vec_t tbl[$];

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model
  logic [31:0] m_ram [int];
  logic [31:0] m_gpio;
  logic [31:0] m_cycle;
  logic [7:0]  m_q[$];
  logic        m_ovf;
  bit          m_live = 1'b0;

  function automatic bit is_ram(input logic [31:0] a);
    return a < DEPTH * 4;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >= 32'h1000_0000) && (a < 32'h1000_0010);
  endfunction

  function automatic void model_read(input logic [31:0] a, output logic [31:0] d,
                                     output bit known);
    int idx;
    int sz;
    known = 1'b1;
    d     = 32'd0;
    if (is_ram(a)) begin
      idx = int'(a / 4);
      if (m_ram.exists(idx)) d = m_ram[idx];
      else known = 1'b0;
    end else if (is_mmio(a)) begin
      sz = m_q.size();
      case ((a - 32'h1000_0000) / 4)
        0: d = m_gpio;
        1: d = m_cycle;
        2: d = 32'd0;
        default: d = (m_ovf ? 32'h8000_0000 : 32'd0) + 32'(sz * 4)
                     + (sz == 0 ? 32'd2 : 32'd0) + (sz == FIFO_DEPTH ? 32'd1 : 32'd0);
      endcase
    end
  endfunction

  task automatic model_edge(input logic rst_n, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic ready);
    logic [31:0] next_cycle;
    if (!rst_n) begin
      m_gpio  = 32'd0;
      m_cycle = 32'd0;
      m_q.delete();
      m_ovf   = 1'b0;
      m_live  = 1'b1;
      return;
    end
    if (!m_live) return;
    next_cycle = m_cycle + 32'd1;
    if (ready && m_q.size() > 0) void'(m_q.pop_front());
    if (we) begin
      if (is_ram(addr)) begin
        m_ram[int'(addr / 4)] = wdata;
      end else if (is_mmio(addr)) begin
        case ((addr - 32'h1000_0000) / 4)
          0: m_gpio = wdata;
          1: next_cycle = wdata;
          2: begin
            if (m_q.size() < FIFO_DEPTH) m_q.push_back(wdata[7:0]);
            else m_ovf = 1'b1;
          end
          default: m_ovf = 1'b0;
        endcase
      end
    end
    m_cycle = next_cycle;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One bus cycle: drive after the falling edge, compare, then let the rising edge commit.
  task automatic apply(input vec_t v);
    logic [31:0] d;
    bit          known;
    @(negedge clk);
    reset              = v.rst_n;
    mem_write_signal   = v.we;
    mem_addr_bus       = v.addr;
    mem_write_data_bus = v.wdata;
    con_ready          = v.ready;
    #1;
    if (m_live) begin
      model_read(v.addr, d, known);
      if (known) check("rdata_model", mem_read_data_bus, d);
      check("gpio_out", gpio_out, m_gpio);
      check("con_valid", 32'(con_valid), 32'(m_q.size() != 0));
      if (m_q.size() > 0) check("con_data_model", 32'(con_data), 32'(m_q[0]));
    end
    if (v.chk_rd) check("rdata_table", mem_read_data_bus, v.exp_rd);
    if (v.chk_con) check("con_data_table", 32'(con_data), 32'(v.exp_con));
    @(posedge clk);
    model_edge(v.rst_n, v.we, v.addr, v.wdata, v.ready);
  endtask

  task automatic add(input logic rst_n, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic ready, input logic chk_rd,
                     input logic [31:0] exp_rd, input logic chk_con, input logic [7:0] exp_con);
    vec_t v;
    v.rst_n = rst_n; v.we = we; v.addr = addr; v.wdata = wdata; v.ready = ready;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.chk_con = chk_con; v.exp_con = exp_con;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t        v;
    logic [31:0] unmapped [5];
    reset              = 1'b0;
    mem_write_signal   = 1'b0;
    mem_addr_bus       = 32'd0;
    mem_write_data_bus = 32'd0;
    con_ready          = 1'b0;

    // Reset, RAM write/read, out-of-range address
    add(0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 8'h0);
    add(0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 8'h0);
    add(1, 1, 32'h10,  32'hDEADBEEF, 0, 0, 32'h0,        0, 8'h0);
    add(1, 1, 32'h14,  32'h12345678, 0, 0, 32'h0,        0, 8'h0);
    add(1, 0, 32'h10,  32'h0,        0, 1, 32'hDEADBEEF, 0, 8'h0);
    add(1, 0, 32'h14,  32'h0,        0, 1, 32'h12345678, 0, 8'h0);
    add(1, 0, 32'h13,  32'h0,        0, 1, 32'hDEADBEEF, 0, 8'h0);
    add(1, 1, 32'h0,   32'h11111111, 0, 0, 32'h0,        0, 8'h0);
    add(1, 1, 32'h400, 32'hCAFEF00D, 0, 1, 32'h0,        0, 8'h0);
    add(1, 0, 32'h400, 32'h0,        0, 1, 32'h0,        0, 8'h0);
    add(1, 0, 32'h0,   32'h0,        0, 1, 32'h11111111, 0, 8'h0);
    // GPIO, then reset keeps RAM
    add(1, 1, AGpio,   32'hA5,       0, 1, 32'h0,        0, 8'h0);
    add(1, 0, AGpio,   32'h0,        0, 1, 32'hA5,       0, 8'h0);
    add(0, 0, 32'h10,  32'h0,        0, 1, 32'hDEADBEEF, 0, 8'h0);
    add(1, 0, 32'h10,  32'h0,        0, 1, 32'hDEADBEEF, 0, 8'h0);
    // CYCLE counts edges since reset, then load and wrap
    for (int k = 1; k <= 10; k++) add(1, 0, ACyc, 32'h0, 0, 1, 32'(k), 0, 8'h0);
    add(1, 1, ACyc, 32'hFFFFFFFE, 0, 1, 32'd11,        0, 8'h0);
    add(1, 0, ACyc, 32'h0,        0, 1, 32'hFFFFFFFE,  0, 8'h0);
    add(1, 0, ACyc, 32'h0,        0, 1, 32'hFFFFFFFF,  0, 8'h0);
    add(1, 0, ACyc, 32'h0,        0, 1, 32'h0,         0, 8'h0);
    // FIFO fill past full, drain, clear overflow
    for (int b = 8'h41; b <= 8'h45; b++) add(1, 1, ACon, 32'(b), 0, 1, 32'h0, 0, 8'h0);
    add(1, 0, AStat, 32'h0, 0, 1, 32'h80000011, 1, 8'h41);
    add(1, 0, AStat, 32'h0, 1, 1, 32'h80000011, 1, 8'h41);
    add(1, 0, AStat, 32'h0, 1, 1, 32'h8000000C, 1, 8'h42);
    add(1, 0, AStat, 32'h0, 1, 1, 32'h80000008, 1, 8'h43);
    add(1, 0, AStat, 32'h0, 1, 1, 32'h80000004, 1, 8'h44);
    add(1, 0, AStat, 32'h0, 0, 1, 32'h80000002, 0, 8'h0);
    add(1, 1, AStat, 32'h0, 0, 1, 32'h80000002, 0, 8'h0);
    add(1, 0, AStat, 32'h0, 0, 1, 32'h00000002, 0, 8'h0);
    // Push and pop on the same edge while full
    for (int b = 8'h61; b <= 8'h64; b++) add(1, 1, ACon, 32'(b), 0, 1, 32'h0, 0, 8'h0);
    add(1, 1, ACon,  32'h5A, 1, 1, 32'h0,  1, 8'h61);
    add(1, 0, AStat, 32'h0,  0, 1, 32'h11, 1, 8'h62);
    add(1, 0, AStat, 32'h0,  1, 1, 32'h11, 1, 8'h62);
    add(1, 0, AStat, 32'h0,  1, 1, 32'h0C, 1, 8'h63);
    add(1, 0, AStat, 32'h0,  1, 1, 32'h08, 1, 8'h64);
    add(1, 0, AStat, 32'h0,  1, 1, 32'h04, 1, 8'h5A);
    add(1, 0, AStat, 32'h0,  0, 1, 32'h02, 0, 8'h0);
    // Reset with queued bytes and a simultaneous push
    add(1, 1, ACon,  32'h71, 0, 1, 32'h0,  0, 8'h0);
    add(1, 1, ACon,  32'h72, 0, 1, 32'h0,  1, 8'h71);
    add(1, 0, AStat, 32'h0,  0, 1, 32'h08, 1, 8'h71);
    add(0, 1, ACon,  32'h73, 1, 1, 32'h0,  1, 8'h71);
    add(1, 0, AStat, 32'h0,  0, 1, 32'h02, 0, 8'h0);

    foreach (tbl[i]) apply(tbl[i]);

    // Random traffic against the model
    unmapped[0] = 32'h0000_0400;
    unmapped[1] = 32'h0000_1000;
    unmapped[2] = 32'h1000_0010;
    unmapped[3] = 32'h2000_0000;
    unmapped[4] = 32'hFFFF_FFFC;
    for (int n = 0; n < 3000; n++) begin
      v.rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      v.we    = ($urandom_range(0, 2) == 0);
      v.ready = ($urandom_range(0, 2) == 0);
      v.wdata = $urandom;
      case ($urandom_range(0, 6))
        0, 1:    v.addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
        2:       v.addr = unmapped[$urandom_range(0, 4)];
        3, 4:    v.addr = ACon;
        default: v.addr = AGpio + 32'($urandom_range(0, 3) * 4);
      endcase
      v.chk_rd  = 1'b0;
      v.exp_rd  = 32'h0;
      v.chk_con = 1'b0;
      v.exp_con = 8'h0;
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv32e_data_mem.md
# rv32e_data_mem

Data-side responder for the `rv32e_cpu` memory bus. It decodes the CPU's address, write-data and write-strobe outputs and serves them from a word RAM plus a small memory-mapped I/O page. The I/O page has a GPIO output register, a free-running cycle counter and a byte console FIFO with a valid/ready drain port. The block sits beside the CPU at top level, and its read data feeds the CPU's `mem_read_data_bus` input.

## Interface
- `DEPTH`, default 256: RAM size in 32-bit words. Must be a power of two.
- `FIFO_DEPTH`, default 4: console FIFO entries. Must be a power of two, ≥2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `mem_addr_bus`  in  32  byte address from the CPU.
- `mem_write_data_bus`  in  32  store data from the CPU.
- `mem_write_signal`  in  1  store strobe; high = commit a write at this edge.
- `mem_read_data_bus`  out  32  read data, combinational from address and current state.
- `gpio_out`  out  32  GPIO register contents.
- `con_data`  out  8  FIFO head byte.
- `con_valid`  out  1  FIFO non-empty.
- `con_ready`  in  1  consumer accepts the head byte at this edge when `con_valid` is high.

## Operation
- Access granularity is whole words only, because the CPU issues only LW/SW. `addr[1:0]` is ignored.
- **RAM region:** an access hits RAM when `addr[31:log2(DEPTH)+2]==0`. The word index is `addr[log2(DEPTH)+1:2]`.
  - Reset does not change RAM contents.
- **MMIO region:** an access hits MMIO when `addr[31:4]==28'h1000000`.
  - 0x10000000 GPIO, read/write. Reset value 0.
  - 0x10000004 CYCLE, read/write. Increments by 1 every clock; wraps from 0xFFFFFFFF to 0. A write loads the write data, and the load takes priority over that edge's increment.
  - 0x10000008 CON_DATA, write-only. A write pushes `wdata[7:0]` into the FIFO. Reads return 0.
  - 0x1000000C CON_STATUS. Read layout:
    - bit0 full
    - bit1 empty
    - bits[log2(FIFO_DEPTH)+2:2] occupancy count
    - bit31 sticky overflow
    - all other bits 0
  - A write of any value to CON_STATUS clears overflow.
- Any other address is unmapped: reads return 0 and writes are ignored.
- **FIFO rules:**
  - Push is accepted if not full, or if a pop occurs on the same edge.
  - A rejected push drops the byte and sets overflow.
  - Pop happens when `con_valid && con_ready`.
  - Simultaneous push and pop leaves the count unchanged, and the data order is preserved.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
  - `con_data` is undefined when empty; the bench must not check it then.
- **Reset** (`reset==0` at an edge) sets:
  - GPIO=0, CYCLE=0, FIFO empty, overflow=0.
  - Outputs after that edge: `gpio_out=0`, `con_valid=0`, `mem_read_data_bus`= read of the current address under reset state (RAM unchanged).
  - Reset mid-FIFO discards all queued bytes.
  - Reset overrides any write or pop at that edge.

## Timing
- **Read latency is zero:** `mem_read_data_bus` follows `mem_addr_bus` combinationally.
  - The CPU registers the address at the end of DECODE and samples data at the end of EXECUTE, so the data is valid one full cycle before it is sampled.
- **Write:**
  - Committed at each rising edge where `mem_write_signal==1`.
  - The CPU raises the strobe at the end of EXECUTE and drops it at the end of WRITE_BACK, so exactly one edge sees it high and exactly one write occurs per SW.
  - A read of the same address in the write cycle returns old data; new data is visible after the edge.
- **CYCLE:** a read returns the pre-edge value. It is 0 in the first cycle after reset deasserts, then 1, 2, ...
- **FIFO status:** `con_valid` and CON_STATUS update in the cycle after the push/pop edge. No combinational path exists from `con_ready` to any output.

## Test plan
- **RAM write/read:** write 0xDEADBEEF to 0x00000010 and 0x12345678 to 0x00000014 → reads return those values. Address 0x00000013 reads 0xDEADBEEF. Address 0x00000400 (DEPTH=256) reads 0 and writes there do not alias word 0.
- **GPIO:** write 0x000000A5 to 0x10000000 → `gpio_out`=0x000000A5 the next cycle. Assert reset → `gpio_out`=0 and RAM word 0x10 still reads 0xDEADBEEF.
- **CYCLE:** release reset, read 0x10000004 after 10 edges → 10. Write 0xFFFFFFFE → the next two cycles read 0xFFFFFFFE then 0xFFFFFFFF, and the cycle after reads 0 (wrap).
- **FIFO fill and overflow:** hold `con_ready=0` and write bytes 0x41..0x45 to 0x10000008 (FIFO_DEPTH=4) → CON_STATUS = full=1, count=4, overflow=1. Drain with `con_ready=1` → `con_data` sequence 0x41,0x42,0x43,0x44, then `con_valid=0` and empty=1. Write to CON_STATUS → overflow=0.
- **Simultaneous push/pop at full:** FIFO full, `con_ready=1`, push 0x5A on the same edge → count stays 4, no overflow, 0x5A emerges last.
- **Reset mid-operation:** FIFO holding 2 bytes, drive `reset=0` for one edge while `mem_write_signal=1` to CON_DATA → `con_valid=0`, count=0, and the written byte is not queued.
